updn_counter_param: RTL

Parametrised, synchronous up/down counter with load, wrap or saturate mode, terminal-count pulse, and sticky overflow flag. It is the configurable successor to the fixed 8-bit free-running counter. It is used wherever the design needs an event counter, timeout, or tick divider. A compile-time prescaler option lets one instance act as a clock-enable divider.

---
 rtl/updn_counter_param.sv | 57 +++++
 1 files changed

// File: rtl/updn_counter_param.sv
// updn_counter_param: parametrised up/down counter with load, wrap/saturate, tc pulse and sticky ovf; COUNTER_PRESCALE_EN adds a step prescaler
module updn_counter_param #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);
  logic tick, step, at_max, at_zero, bnd;
  logic [WIDTH-1:0] nxt, ld;
`ifdef COUNTER_PRESCALE_EN
  localparam int PW = PRESCALE > 2 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre;
  assign tick = pre == PW'(PRESCALE - 1);
  // prescaler advances on every unloaded en cycle and wraps on the stepping cycle
  always_ff @(posedge clk) begin
    if (rst || load) pre <= '0;
    else if (en) pre <= tick ? '0 : pre + 1'b1;
  end
`else
  assign tick = 1'b1;
`endif
  assign step = en && !load && tick;
  assign at_max = count == MAX_VAL;
  assign at_zero = count == '0;
  assign bnd = step && (up ? at_max : at_zero);
  assign ld = load_val > MAX_VAL ? MAX_VAL : load_val;
  assign zero = at_zero;
  // next count for a step, resolving the boundary as wrap or hold
  always_comb begin
    nxt = up ? (at_max ? (SATURATE ? MAX_VAL : '0) : count + 1'b1)
             : (at_zero ? (SATURATE ? '0 : MAX_VAL) : count - 1'b1);
  end
  // count/tc/ovf registers; a boundary set of ovf beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc <= 1'b0;
      ovf <= 1'b0;
    end else begin
      count <= load ? ld : step ? nxt : count;
      tc <= bnd;
      ovf <= bnd || (ovf && !clr_ovf);
    end
  end
endmodule
